// File: rtl/register_read_multi_pkg.sv
// Shared types for the register-read stage: dispatch/exec packet layouts and
// the output buffer state encoding.
package register_read_multi_pkg;

    localparam int XLEN   = 32;
    localparam int PREG_W = 6;

    typedef struct packed {
        logic              instr_valid;
        logic [XLEN-1:0]   pc;
        logic [PREG_W-1:0] dst_preg;
        logic [PREG_W-1:0] src1_preg;
        logic [PREG_W-1:0] src2_preg;
        logic [XLEN-1:0]   imm_val;
    } disp_packet_t;

    typedef struct packed {
        logic              instr_valid;
        logic [XLEN-1:0]   pc;
        logic [PREG_W-1:0] dst_preg;
        logic [PREG_W-1:0] src1_preg;
        logic [PREG_W-1:0] src2_preg;
        logic [XLEN-1:0]   imm_val;
        logic [XLEN-1:0]   src1_val;
        logic [XLEN-1:0]   src2_val;
    } exec_packet_t;

    typedef enum logic [1:0] {
        RR_EMPTY = 2'd0,
        RR_MAIN  = 2'd1,
        RR_SKID  = 2'd2
    } rr_state_t;

endpackage

// File: rtl/register_read_multi_if.sv
// Bundle of scheduler, register-file, forwarding and execute-side signals of
// the register-read stage. slave = the stage itself, master = its environment.
interface register_read_multi_if
    import register_read_multi_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int NUM_FWD   = 3
) ();

    logic [NUM_LANES-1:0]             in_valid;
    disp_packet_t [NUM_LANES-1:0]     in_pkt;
    logic                             in_ready;

    logic [NUM_LANES-1:0][PREG_W-1:0] rf_src1_preg;
    logic [NUM_LANES-1:0][PREG_W-1:0] rf_src2_preg;
    logic [NUM_LANES-1:0][XLEN-1:0]   rf_src1_val;
    logic [NUM_LANES-1:0][XLEN-1:0]   rf_src2_val;

    logic [NUM_FWD-1:0]               fwd_valid;
    logic [NUM_FWD-1:0][PREG_W-1:0]   fwd_preg;
    logic [NUM_FWD-1:0][XLEN-1:0]     fwd_val;

    logic [NUM_LANES-1:0]             out_valid;
    exec_packet_t [NUM_LANES-1:0]     out_pkt;
    logic                             out_ready;

    logic                             flush;
    logic [31:0]                      stall_cnt;

    modport slave (
        input  in_valid, in_pkt, rf_src1_val, rf_src2_val,
        input  fwd_valid, fwd_preg, fwd_val, out_ready, flush,
        output in_ready, rf_src1_preg, rf_src2_preg, out_valid, out_pkt, stall_cnt
    );

    modport master (
        output in_valid, in_pkt, rf_src1_val, rf_src2_val,
        output fwd_valid, fwd_preg, fwd_val, out_ready, flush,
        input  in_ready, rf_src1_preg, rf_src2_preg, out_valid, out_pkt, stall_cnt
    );

endinterface

// File: rtl/register_read_multi_rr_operand_sel.sv
// Priority forwarding mux for a single source operand: preg 0 reads as zero,
// otherwise the lowest-index matching forward source beats the register file.
module rr_operand_sel #(
    parameter int NUM_FWD = 3,
    parameter int PREG_W  = 6,
    parameter int XLEN    = 32
) (
    input  logic [PREG_W-1:0]               preg_i,
    input  logic [XLEN-1:0]                 rf_val_i,
    input  logic [NUM_FWD-1:0]              fwd_valid_i,
    input  logic [NUM_FWD-1:0][PREG_W-1:0]  fwd_preg_i,
    input  logic [NUM_FWD-1:0][XLEN-1:0]    fwd_val_i,
    output logic [XLEN-1:0]                 val_o
);

    always_comb begin
        val_o = rf_val_i;
        // Walk from lowest priority upward so the youngest producer wins last.
        for (int f = NUM_FWD - 1; f >= 0; f--) begin
            if (fwd_valid_i[f] && (fwd_preg_i[f] == preg_i)) begin
                val_o = fwd_val_i[f];
            end
        end
        if (preg_i == '0) begin
            val_o = '0;
        end
    end

endmodule

// File: rtl/register_read_multi.sv
// Multi-lane register-read stage: resolves operands at accept time and holds
// the resulting bundle in a main register backed by one skid entry.
module register_read_multi
    import register_read_multi_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int NUM_FWD   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    register_read_multi_if.slave bus
);

    rr_state_t                      state_q, state_d;
    exec_packet_t [NUM_LANES-1:0]   main_pkt_q, main_pkt_d;
    exec_packet_t [NUM_LANES-1:0]   skid_pkt_q, skid_pkt_d;
    logic [NUM_LANES-1:0]           main_valid_q, main_valid_d;
    logic [NUM_LANES-1:0]           skid_valid_q, skid_valid_d;
    logic [31:0]                    stall_cnt_q;

    exec_packet_t [NUM_LANES-1:0]   cap_pkt;
    logic [NUM_LANES-1:0][XLEN-1:0] src1_val;
    logic [NUM_LANES-1:0][XLEN-1:0] src2_val;
    logic                           in_ready;
    logic                           accept;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign bus.rf_src1_preg[gi] = bus.in_pkt[gi].src1_preg;
            assign bus.rf_src2_preg[gi] = bus.in_pkt[gi].src2_preg;

            rr_operand_sel #(.NUM_FWD(NUM_FWD), .PREG_W(PREG_W), .XLEN(XLEN)) u_src1_sel (
                .preg_i      (bus.in_pkt[gi].src1_preg),
                .rf_val_i    (bus.rf_src1_val[gi]),
                .fwd_valid_i (bus.fwd_valid),
                .fwd_preg_i  (bus.fwd_preg),
                .fwd_val_i   (bus.fwd_val),
                .val_o       (src1_val[gi])
            );

            rr_operand_sel #(.NUM_FWD(NUM_FWD), .PREG_W(PREG_W), .XLEN(XLEN)) u_src2_sel (
                .preg_i      (bus.in_pkt[gi].src2_preg),
                .rf_val_i    (bus.rf_src2_val[gi]),
                .fwd_valid_i (bus.fwd_valid),
                .fwd_preg_i  (bus.fwd_preg),
                .fwd_val_i   (bus.fwd_val),
                .val_o       (src2_val[gi])
            );
        end
    endgenerate

    always_comb begin
        cap_pkt = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            cap_pkt[l].instr_valid = bus.in_pkt[l].instr_valid;
            cap_pkt[l].pc          = bus.in_pkt[l].pc;
            cap_pkt[l].dst_preg    = bus.in_pkt[l].dst_preg;
            cap_pkt[l].src1_preg   = bus.in_pkt[l].src1_preg;
            cap_pkt[l].src2_preg   = bus.in_pkt[l].src2_preg;
            cap_pkt[l].imm_val     = bus.in_pkt[l].imm_val;
            cap_pkt[l].src1_val    = src1_val[l];
            cap_pkt[l].src2_val    = src2_val[l];
        end
    end

    // Ready depends only on registered state, never on out_ready.
    assign in_ready = rst_n & (state_q != RR_SKID) & ~bus.flush;
    assign accept   = in_ready & (|bus.in_valid);

    always_comb begin
        state_d      = state_q;
        main_pkt_d   = main_pkt_q;
        main_valid_d = main_valid_q;
        skid_pkt_d   = skid_pkt_q;
        skid_valid_d = skid_valid_q;
        if (bus.flush) begin
            state_d      = RR_EMPTY;
            main_pkt_d   = '0;
            main_valid_d = '0;
            skid_pkt_d   = '0;
            skid_valid_d = '0;
        end else begin
            case (state_q)
                RR_EMPTY: begin
                    if (accept) begin
                        state_d      = RR_MAIN;
                        main_pkt_d   = cap_pkt;
                        main_valid_d = bus.in_valid;
                    end
                end
                RR_MAIN: begin
                    if (bus.out_ready) begin
                        if (accept) begin
                            main_pkt_d   = cap_pkt;
                            main_valid_d = bus.in_valid;
                        end else begin
                            state_d      = RR_EMPTY;
                            main_valid_d = '0;
                        end
                    end else if (accept) begin
                        state_d      = RR_SKID;
                        skid_pkt_d   = cap_pkt;
                        skid_valid_d = bus.in_valid;
                    end
                end
                RR_SKID: begin
                    if (bus.out_ready) begin
                        state_d      = RR_MAIN;
                        main_pkt_d   = skid_pkt_q;
                        main_valid_d = skid_valid_q;
                        skid_valid_d = '0;
                    end
                end
                default: state_d = RR_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RR_EMPTY;
            main_pkt_q   <= '0;
            main_valid_q <= '0;
            skid_pkt_q   <= '0;
            skid_valid_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            main_pkt_q   <= main_pkt_d;
            main_valid_q <= main_valid_d;
            skid_pkt_q   <= skid_pkt_d;
            skid_valid_q <= skid_valid_d;
            if ((|main_valid_q) && !bus.out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = main_valid_q;
    assign bus.out_pkt   = main_pkt_q;
    assign bus.stall_cnt = stall_cnt_q;

endmodule
